// File: rtl/mem_responder.sv
// Word-addressed memory responder: one request at a time, LATENCY wait states, one-cycle response.
// Optional completion mailbox (host_done/host_code) compiled in with MEM_RESP_TOHOST_EN.
module mem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned TOHOST_ADDR = 84
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef MEM_RESP_TOHOST_EN
  ,
  output logic        host_done,
  output logic [31:0] host_code
`endif
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned CW        = 4;
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            ready_q, ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   idx;
  logic            acc_err;
  logic            mem_we;

  assign idx     = addr_q[AW+1:2];
  assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q >= MEM_BYTES);

  // Next-state and response logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CW'(LATENCY);
          ready_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          mem_we      = write_q && !acc_err;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (!write_q && !acc_err) ? mem_q[idx] : 32'h0;
          state_d     = RESP;
        end
      end
      RESP: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is deliberately not reset; a committed write survives a later reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef MEM_RESP_TOHOST_EN
  logic        host_done_q, host_done_d;
  logic [31:0] host_code_q, host_code_d;

  // Mailbox snoops committed writes; done is sticky, code tracks the latest value
  always_comb begin
    host_done_d = host_done_q;
    host_code_d = host_code_q;
    if (mem_we && (addr_q == 32'(TOHOST_ADDR))) begin
      host_done_d = 1'b1;
      host_code_d = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      host_done_q <= 1'b0;
      host_code_q <= '0;
    end else begin
      host_done_q <= host_done_d;
      host_code_q <= host_code_d;
    end
  end

  assign host_done = host_done_q;
  assign host_code = host_code_q;
`else
  logic unused_tohost;
  assign unused_tohost = ^32'(TOHOST_ADDR);
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 instance for function/timing, LATENCY=0 instance for throughput.
module tb_mem_responder;

  logic        clk;
  logic        n_reset;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

`ifdef MEM_RESP_TOHOST_EN
  logic        host_done, host_done0;
  logic [31:0] host_code, host_code0;
`endif

  int vectors;
  int miscompares;

  mem_responder #(.DEPTH(64), .LATENCY(2), .TOHOST_ADDR(84)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
`ifdef MEM_RESP_TOHOST_EN
    ,
    .host_done (host_done),
    .host_code (host_code)
`endif
  );

  mem_responder #(.DEPTH(64), .LATENCY(0), .TOHOST_ADDR(84)) dut0 (
    .clk       (clk),
    .n_reset   (n_reset),
    .req_valid (req_valid0),
    .req_write (1'b0),
    .req_addr  (32'h0),
    .req_wdata (32'h0),
    .req_ready (req_ready0),
    .rsp_valid (rsp_valid0),
    .rsp_rdata (rsp_rdata0),
    .rsp_err   (rsp_err0)
`ifdef MEM_RESP_TOHOST_EN
    ,
    .host_done (host_done0),
    .host_code (host_code0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One LATENCY=2 transaction; checks handshake timing, returns response fields
  task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
    int lat;
    logic rdy_busy;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rdy_busy  = req_ready;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    chk({tag, "_ready_busy"}, 32'(rdy_busy), 32'h0);
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    @(posedge clk); #1;
    chk({tag, "_valid_pulse"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_ready_again"}, 32'(req_ready), 32'h1);
  endtask

  logic [31:0] rd;
  logic        er;
  logic        seen;

  initial begin
    vectors = 0; miscompares = 0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_valid0 = 1'b0;
    n_reset = 1'b1;
    #2 n_reset = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
`ifdef MEM_RESP_TOHOST_EN
    chk("rst_host_done", 32'(host_done), 32'h0);
    chk("rst_host_code", host_code, 32'h0);
`endif
    @(negedge clk); @(negedge clk);
    n_reset = 1'b1;

    // Write then read-back of address 8
    xact("wr8", 1'b1, 32'h8, 32'h1234_5678, rd, er);
    chk("wr8_err", 32'(er), 32'h0);
    chk("wr8_rdata", rd, 32'h0);
    xact("rd8", 1'b0, 32'h8, 32'h0, rd, er);
    chk("rd8_rdata", rd, 32'h1234_5678);
    chk("rd8_err", 32'(er), 32'h0);

    // Misaligned write must not disturb the aligned word
    xact("wr28", 1'b1, 32'h28, 32'hCAFE_F00D, rd, er);
    xact("wr2a", 1'b1, 32'h2A, 32'h0000_DEAD, rd, er);
    chk("wr2a_err", 32'(er), 32'h1);
    xact("rd28", 1'b0, 32'h28, 32'h0, rd, er);
    chk("rd28_rdata", rd, 32'hCAFE_F00D);
    chk("rd28_err", 32'(er), 32'h0);
    xact("rd2b", 1'b0, 32'h2B, 32'h0, rd, er);
    chk("rd2b_err", 32'(er), 32'h1);
    chk("rd2b_rdata", rd, 32'h0);

    // Range boundary: last word is legal, 256 is out of range
    xact("wrfc", 1'b1, 32'hFC, 32'hA5A5_0001, rd, er);
    xact("rdfc", 1'b0, 32'hFC, 32'h0, rd, er);
    chk("rdfc_rdata", rd, 32'hA5A5_0001);
    chk("rdfc_err", 32'(er), 32'h0);
    xact("rd100", 1'b0, 32'h100, 32'h0, rd, er);
    chk("rd100_err", 32'(er), 32'h1);
    chk("rd100_rdata", rd, 32'h0);
    xact("wr100", 1'b1, 32'h100, 32'hFFFF_FFFF, rd, er);
    chk("wr100_err", 32'(er), 32'h1);
    xact("rd0", 1'b0, 32'h0, 32'h0, rd, er);
    chk("rd0_noalias", 32'(rd == 32'hFFFF_FFFF), 32'h0);

    // LATENCY=0 with req_valid held: ready 1,0,0 repeating, response on the commit edge
    @(negedge clk);
    req_valid0 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      chk($sformatf("thr_ready_%0d", k), 32'(req_ready0), 32'((k % 3) == 0));
      chk($sformatf("thr_valid_%0d", k), 32'(rsp_valid0), 32'((k % 3) == 2));
    end
    @(negedge clk);
    req_valid0 = 1'b0;

`ifdef MEM_RESP_TOHOST_EN
    xact("mb80", 1'b1, 32'd80, 32'h5, rd, er);
    chk("mb80_done", 32'(host_done), 32'h0);
    xact("mb84a", 1'b1, 32'd84, 32'h7, rd, er);
    chk("mb84a_done", 32'(host_done), 32'h1);
    chk("mb84a_code", host_code, 32'h7);
    xact("mb84b", 1'b1, 32'd84, 32'h9, rd, er);
    chk("mb84b_done", 32'(host_done), 32'h1);
    chk("mb84b_code", host_code, 32'h9);
    xact("mbrd84", 1'b0, 32'd84, 32'h0, rd, er);
    chk("mbrd84_rdata", rd, 32'h9);
`endif

    // Reset during BUSY abandons an uncommitted write to 80
    xact("wr80", 1'b1, 32'd80, 32'h11, rd, er);
    xact("rd8b", 1'b0, 32'h8, 32'h0, rd, er);
    chk("rd8b_rdata", rd, 32'h1234_5678);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd80; req_wdata = 32'h99;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("busy_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    chk("arst_ready", 32'(req_ready), 32'h1);
    chk("arst_valid", 32'(rsp_valid), 32'h0);
    chk("arst_rdata", rsp_rdata, 32'h0);
    chk("arst_err", 32'(rsp_err), 32'h0);
`ifdef MEM_RESP_TOHOST_EN
    chk("arst_host_done", 32'(host_done), 32'h0);
    chk("arst_host_code", host_code, 32'h0);
`endif
    @(negedge clk);
    n_reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid;
    end
    chk("arst_no_rsp", 32'(seen), 32'h0);
    xact("rd80", 1'b0, 32'd80, 32'h0, rd, er);
    chk("rd80_rdata", rd, 32'h11);
    chk("rd80_err", 32'(er), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
